// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian byte stream into 32-bit words and writes them into instruction memory.
// Timing: each word's write strobe is high for one cycle, starting at the edge that accepts its 4th byte.
// Flow control: rx_ready is high in HDR/DATA/CHK and low in DONE/ERR. Define IMEM_LOADER_CHECKSUM_EN to add the trailing XOR checksum byte.
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  // Largest legal word count is the full memory capacity.
  localparam logic [32:0]       CAP  = 33'(1) << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_HDR, S_DATA, S_CHK, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_HDR, S_DATA, S_DONE, S_ERR} state_t;
`endif

  state_t            state, state_nxt;
  logic [1:0]        byte_cnt;
  logic [23:0]       hdr_sr;
  logic [23:0]       word_sr;
  logic [ADDR_W:0]   n_words;
  logic [ADDR_W:0]   wl;

  logic              accept;
  logic              last_byte;
  logic [31:0]       hdr_full;
  logic [31:0]       word_full;
  logic              data_full;
  logic              data_take;
  logic              word_done;
  logic [ADDR_W:0]   wl_inc;
  logic              restart;

  assign accept    = rx_valid && rx_ready;
  assign last_byte = (byte_cnt == 2'd3);
  assign hdr_full  = {hdr_sr, rx_data};
  assign word_full = {word_sr, rx_data};
  // All declared words written; any byte arriving in DATA now is not part of a word.
  assign data_full = (wl == n_words);
  assign data_take = accept && (state == S_DATA) && !data_full;
  assign word_done = data_take && last_byte;
  assign wl_inc    = wl + {{ADDR_W{1'b0}}, 1'b1};
  assign restart   = ((state == S_DONE) || (state == S_ERR)) && reload;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] chk_acc;

  // XOR of every stream byte before the checksum byte
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chk_acc <= 8'h00;
    end else if (restart) begin
      chk_acc <= 8'h00;
    end else if (accept && (state != S_CHK)) begin
      chk_acc <= chk_acc ^ rx_data;
    end
  end
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_HDR;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_HDR: begin
        if (accept && last_byte) begin
          if (hdr_full == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_nxt = S_CHK;
`else
            state_nxt = S_DONE;
`endif
          end else if ({1'b0, hdr_full} > CAP) begin
            state_nxt = S_ERR;
          end else begin
            state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum byte may follow the last word back-to-back
        if (word_done && (wl_inc == n_words)) state_nxt = S_CHK;
`else
        // Leave one cycle after the final write strobe
        if (data_full) state_nxt = S_DONE;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) state_nxt = (rx_data == chk_acc) ? S_DONE : S_ERR;
      end
`endif
      S_DONE, S_ERR: begin
        if (reload) state_nxt = S_HDR;
      end
      default: state_nxt = S_HDR;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    rx_ready  = 1'b1;
    core_hold = 1'b1;
    load_done = 1'b0;
    load_err  = 1'b0;
    case (state)
      S_DONE: begin
        rx_ready  = 1'b0;
        core_hold = 1'b0;
        load_done = 1'b1;
      end
      S_ERR: begin
        rx_ready = 1'b0;
        load_err = 1'b1;
      end
      default: ;
    endcase
  end

  // Header/word assembly, write port and word counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt   <= 2'd0;
      hdr_sr     <= 24'd0;
      word_sr    <= 24'd0;
      n_words    <= '0;
      wl         <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
    end else begin
      imem_we <= 1'b0;
      if (restart) begin
        byte_cnt <= 2'd0;
        hdr_sr   <= 24'd0;
        wl       <= '0;
        n_words  <= '0;
      end else if (accept && (state == S_HDR)) begin
        hdr_sr   <= hdr_full[23:0];
        byte_cnt <= byte_cnt + 2'd1;
        // Truncation only matters for oversize counts, which go to ERR
        if (last_byte) n_words <= hdr_full[ADDR_W:0];
      end else if (data_take) begin
        word_sr  <= word_full[23:0];
        byte_cnt <= byte_cnt + 2'd1;
        if (last_byte) begin
          imem_we    <= 1'b1;
          imem_addr  <= BASE + wl[ADDR_W-1:0];
          imem_wdata <= word_full;
          wl         <= wl_inc;
        end
      end
    end
  end

  assign words_loaded = wl;

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
module tb_imem_loader;
  localparam int AW = 8;
  localparam int B1 = 254;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_valid = 1'b0;
  logic reload = 1'b0;

  logic          rdy   [2];
  logic          we    [2];
  logic [AW-1:0] addr  [2];
  logic [31:0]   wdata [2];
  logic          hold  [2];
  logic          done  [2];
  logic          err   [2];
  logic [AW:0]   wl    [2];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut0 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rdy[0]),
    .reload(reload), .imem_we(we[0]), .imem_addr(addr[0]), .imem_wdata(wdata[0]),
    .core_hold(hold[0]), .load_done(done[0]), .load_err(err[0]), .words_loaded(wl[0]));

  imem_loader #(.ADDR_W(AW), .BASE_ADDR(B1)) dut1 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rdy[1]),
    .reload(reload), .imem_we(we[1]), .imem_addr(addr[1]), .imem_wdata(wdata[1]),
    .core_hold(hold[1]), .load_done(done[1]), .load_err(err[1]), .words_loaded(wl[1]));

  // Write monitor and release-timing capture
  int cyc = 0;
  logic [AW-1:0] wa0[$], wa1[$];
  logic [31:0]   wd0[$], wd1[$];
  int last_we [2];
  int fall    [2];
  logic prev_hold [2];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we[0]) begin wa0.push_back(addr[0]); wd0.push_back(wdata[0]); last_we[0] = cyc; end
    if (we[1]) begin wa1.push_back(addr[1]); wd1.push_back(wdata[1]); last_we[1] = cyc; end
    for (int d = 0; d < 2; d++) begin
      if (prev_hold[d] === 1'b1 && hold[d] === 1'b0) fall[d] = cyc;
      prev_hold[d] = hold[d];
    end
  end

  // Reference stream: word list plus the byte stream derived from it
  logic [7:0]  strm[$];
  logic [31:0] ew[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wa0.delete(); wa1.delete(); wd0.delete(); wd1.delete();
    for (int d = 0; d < 2; d++) begin last_we[d] = -1; fall[d] = -1; end
  endtask

  task automatic fill_random(input int n);
    ew.delete();
    for (int i = 0; i < n; i++) ew.push_back($urandom);
  endtask

  // Header = word count, then words MSB first, optional XOR checksum
  task automatic build(input bit bad_chk);
    logic [31:0] n;
    logic [7:0]  x;
    n = ew.size();
    strm.delete();
    for (int s = 3; s >= 0; s--) strm.push_back(8'((n >> (8 * s)) & 32'hFF));
    foreach (ew[i]) for (int s = 3; s >= 0; s--) strm.push_back(8'((ew[i] >> (8 * s)) & 32'hFF));
`ifdef IMEM_LOADER_CHECKSUM_EN
    x = 8'h00;
    foreach (strm[i]) x = x ^ strm[i];
    if (bad_chk) x = x ^ 8'h01;
    strm.push_back(x);
`else
    x = {7'd0, bad_chk};
    if (x == 8'hFF) strm.push_back(x);
`endif
  endtask

  // thr: 0 = back-to-back, 1 = idle cycle before each byte, 2 = random idles
  task automatic send_byte(input logic [7:0] b, input int thr);
    int n;
    if (thr == 1 || (thr == 2 && $urandom_range(0, 1) == 1)) step();
    rx_valid = 1'b1;
    rx_data = b;
    n = 0;
    while (rdy[0] !== 1'b1 && n < 20) begin step(); n++; end
    chk("rx_ready_wait", {63'd0, rdy[0]}, 64'd1);
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_range(input int first, input int last, input int thr);
    for (int i = first; i <= last; i++) send_byte(strm[i], thr);
  endtask

  task automatic reload_pulse();
    reload = 1'b1;
    step();
    reload = 1'b0;
    step();
  endtask

  task automatic check_reset(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_we_d%0d", tag, d), {63'd0, we[d]}, 64'd0);
      chk($sformatf("%s_addr_d%0d", tag, d), 64'(addr[d]), 64'd0);
      chk($sformatf("%s_wdata_d%0d", tag, d), 64'(wdata[d]), 64'd0);
      chk($sformatf("%s_hold_d%0d", tag, d), {63'd0, hold[d]}, 64'd1);
      chk($sformatf("%s_done_d%0d", tag, d), {63'd0, done[d]}, 64'd0);
      chk($sformatf("%s_err_d%0d", tag, d), {63'd0, err[d]}, 64'd0);
      chk($sformatf("%s_wl_d%0d", tag, d), 64'(wl[d]), 64'd0);
      chk($sformatf("%s_rdy_d%0d", tag, d), {63'd0, rdy[d]}, 64'd1);
    end
  endtask

  task automatic check_reloaded(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_hold_d%0d", tag, d), {63'd0, hold[d]}, 64'd1);
      chk($sformatf("%s_wl_d%0d", tag, d), 64'(wl[d]), 64'd0);
      chk($sformatf("%s_done_d%0d", tag, d), {63'd0, done[d]}, 64'd0);
      chk($sformatf("%s_err_d%0d", tag, d), {63'd0, err[d]}, 64'd0);
      chk($sformatf("%s_rdy_d%0d", tag, d), {63'd0, rdy[d]}, 64'd1);
    end
  endtask

  // Expected: exp_n words at (base+i) mod 2^AW carrying ew[i], then DONE or ERR
  task automatic check_load(input string tag, input int exp_n, input bit exp_err);
    int base, sz;
    for (int d = 0; d < 2; d++) begin
      base = (d == 0) ? 0 : B1;
      sz = (d == 0) ? wa0.size() : wa1.size();
      chk($sformatf("%s_nwr_d%0d", tag, d), 64'(sz), 64'(exp_n));
      for (int i = 0; i < exp_n && i < sz; i++) begin
        chk($sformatf("%s_addr%0d_d%0d", tag, i, d), 64'((d == 0) ? wa0[i] : wa1[i]), 64'((base + i) % (1 << AW)));
        chk($sformatf("%s_data%0d_d%0d", tag, i, d), 64'((d == 0) ? wd0[i] : wd1[i]), 64'(ew[i]));
      end
      chk($sformatf("%s_wl_d%0d", tag, d), 64'(wl[d]), 64'(exp_n));
      chk($sformatf("%s_done_d%0d", tag, d), {63'd0, done[d]}, {63'd0, !exp_err});
      chk($sformatf("%s_err_d%0d", tag, d), {63'd0, err[d]}, {63'd0, exp_err});
      chk($sformatf("%s_hold_d%0d", tag, d), {63'd0, hold[d]}, {63'd0, exp_err});
      chk($sformatf("%s_rdy_d%0d", tag, d), {63'd0, rdy[d]}, 64'd0);
    end
  endtask

  task automatic run_load(input string tag, input int thr, input bit bad_chk, input bit exp_err);
    build(bad_chk);
    clear_mon();
    send_range(0, strm.size() - 1, thr);
    repeat (3) step();
    check_load(tag, ew.size(), exp_err);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) prev_hold[d] = 1'b1;
    clear_mon();
    repeat (2) step();
    check_reset("reset");
    reset = 1'b1;
    step();

    // Basic two-word program
    ew.delete();
    ew.push_back(32'h2008_0005);
    ew.push_back(32'h0109_5020);
    run_load("basic", 0, 1'b0, 1'b0);
`ifndef IMEM_LOADER_CHECKSUM_EN
    for (int d = 0; d < 2; d++)
      chk($sformatf("release_timing_d%0d", d), 64'(fall[d]), 64'(last_we[d] + 1));
`endif

    reload_pulse();
    check_reloaded("reload1");

    // Same program, source idle on alternate cycles
    run_load("throttle", 1, 1'b0, 1'b0);
    reload_pulse();

    // Random program with random gaps
    fill_random($urandom_range(1, 8));
    run_load("random", 2, 1'b0, 1'b0);
    reload_pulse();

    // Three words: base-254 instance wraps to address 0
    fill_random(3);
    run_load("wrap", 2, 1'b0, 1'b0);
    reload_pulse();
    check_reloaded("reload_wrap");

    // Word count one over capacity
    ew.delete();
    strm.delete();
    strm.push_back(8'h00); strm.push_back(8'h00); strm.push_back(8'h01); strm.push_back(8'h01);
    clear_mon();
    send_range(0, 3, 0);
    repeat (3) step();
    check_load("overflow", 0, 1'b1);
    reload_pulse();

    // Exactly full capacity
    fill_random(1 << AW);
    run_load("full", 0, 1'b0, 1'b0);
    reload_pulse();

    // Empty program
    ew.delete();
    run_load("nzero", 2, 1'b0, 1'b0);
    reload_pulse();

    // Fixed one-word program (checksum 0x01 when enabled)
    ew.delete();
    ew.push_back(32'hAABB_CCDD);
    run_load("one_word", 0, 1'b0, 1'b0);
    reload_pulse();
`ifdef IMEM_LOADER_CHECKSUM_EN
    run_load("bad_chk", 0, 1'b1, 1'b1);
    reload_pulse();
`endif

    // Reset after two data bytes of the first word
    fill_random(2);
    build(1'b0);
    clear_mon();
    send_range(0, 5, 0);
    reset = 1'b0;
    #1;
    check_reset("midreset");
    chk("midreset_nowrite", 64'(wa0.size() + wa1.size()), 64'd0);
    step();
    reset = 1'b1;
    step();
    fill_random(2);
    run_load("after_reset", 2, 1'b0, 1'b0);

    // Reload together with a valid byte: byte must be dropped
    rx_valid = 1'b1;
    rx_data = 8'hFF;
    reload = 1'b1;
    step();
    reload = 1'b0;
    rx_valid = 1'b0;
    check_reloaded("reload_coinc");
    fill_random(2);
    run_load("after_coinc", 2, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
